// File: rtl/rail_sequencer.sv
// N-rail power sequencer: ordered ramp-up with power-good timeout and settle delay,
// reverse-order ramp-down, latched faults. Optional auto-retry via macro AUTO_RETRY_EN.
module rail_sequencer #(
  parameter int NUM_RAILS     = 4,
  parameter int TIMER_WIDTH   = 16,
  parameter int PG_TIMEOUT    = 16000,
  parameter int SETTLE_CYCLES = 6400,
  parameter int RETRY_DELAY   = 32000,
  parameter int RETRY_LIMIT   = 2
) (
  input  logic                 sysclk_i,
  input  logic                 reset_i,
  input  logic                 enable_i,
  input  logic [NUM_RAILS-1:0] pg_i,
  input  logic                 clear_fault_i,
  output logic [NUM_RAILS-1:0] rail_en_o,
  output logic                 all_good_o,
  output logic                 fault_o,
  output logic [NUM_RAILS-1:0] fault_rail_o,
  output logic [2:0]           state_o
);

  localparam int IDX_W = (NUM_RAILS > 1) ? $clog2(NUM_RAILS) : 1;
  localparam int T_MAX = (PG_TIMEOUT > SETTLE_CYCLES)
                       ? ((PG_TIMEOUT > RETRY_DELAY) ? PG_TIMEOUT : RETRY_DELAY)
                       : ((SETTLE_CYCLES > RETRY_DELAY) ? SETTLE_CYCLES : RETRY_DELAY);
  localparam bit CFG_OK = (NUM_RAILS >= 1) && (NUM_RAILS <= 8) &&
                          (((T_MAX - 1) >> TIMER_WIDTH) == 0) &&
                          (PG_TIMEOUT >= 1) && (SETTLE_CYCLES >= 1) &&
                          (RETRY_DELAY >= 2) && (RETRY_LIMIT >= 0);
  localparam logic [NUM_RAILS-1:0] RAIL_ONE = NUM_RAILS'(1);

  if (!CFG_OK) begin : g_cfg_check
    $error("rail_sequencer: parameter set out of range");
  end

  typedef enum logic [2:0] {
    ST_OFF        = 3'd0,
    ST_RAMP_UP    = 3'd1,
    ST_SETTLE     = 3'd2,
    ST_ON         = 3'd3,
    ST_RAMP_DOWN  = 3'd4,
    ST_FAULT      = 3'd5,
    ST_RETRY_WAIT = 3'd6
  } state_t;

  state_t                 state_q, state_d;
  logic [TIMER_WIDTH-1:0] timer_q, timer_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_RAILS-1:0]   rail_en_q, rail_en_d;
  logic                   all_good_q, all_good_d;
  logic                   fault_q, fault_d;
  logic [NUM_RAILS-1:0]   fault_rail_q, fault_rail_d;
  logic [NUM_RAILS-1:0]   mon_s, fail_s, first_fail_s, down_en_s;
`ifdef AUTO_RETRY_EN
  localparam int RETRY_W = $clog2(RETRY_LIMIT + 2);
  logic [RETRY_W-1:0]     retry_q, retry_d;
`endif

  // One-hot of the lowest set bit, so simultaneous failures report the lowest rail.
  function automatic logic [NUM_RAILS-1:0] lowest_one(input logic [NUM_RAILS-1:0] v);
    return v & (~v + NUM_RAILS'(1));
  endfunction

  function automatic logic [NUM_RAILS-1:0] clear_msb(input logic [NUM_RAILS-1:0] v);
    logic [NUM_RAILS-1:0] r;
    logic                 done;
    r    = v;
    done = 1'b0;
    for (int i = NUM_RAILS - 1; i >= 0; i--) begin
      if (!done && v[i]) begin
        r[i] = 1'b0;
        done = 1'b1;
      end
    end
    return r;
  endfunction

  // Rails whose power-good is watched; the ramping rail is exempt until its pg rises.
  always_comb begin
    mon_s = '0;
    case (state_q)
      ST_RAMP_UP: mon_s = rail_en_q & ~(RAIL_ONE << idx_q);
      ST_SETTLE:  mon_s = rail_en_q;
      ST_ON:      mon_s = rail_en_q;
      default:    mon_s = '0;
    endcase
  end

  assign fail_s       = mon_s & ~pg_i;
  assign first_fail_s = lowest_one(fail_s);
  assign down_en_s    = clear_msb(rail_en_q);

  // Next-state logic: fault takes priority over enable drop in every monitored state.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    idx_d        = idx_q;
    rail_en_d    = rail_en_q;
    fault_d      = fault_q;
    fault_rail_d = fault_rail_q;
`ifdef AUTO_RETRY_EN
    retry_d      = retry_q;
`endif
    case (state_q)
      ST_OFF: begin
        timer_d = '0;
        if (enable_i) begin
          state_d   = ST_RAMP_UP;
          idx_d     = '0;
          rail_en_d = RAIL_ONE;
        end else begin
          rail_en_d = '0;
        end
      end
      ST_RAMP_UP: begin
        if (|fail_s) begin
          state_d      = ST_FAULT;
          rail_en_d    = '0;
          fault_d      = 1'b1;
          fault_rail_d = first_fail_s;
          timer_d      = '0;
        end else if (!enable_i) begin
          state_d   = (down_en_s == '0) ? ST_OFF : ST_RAMP_DOWN;
          rail_en_d = down_en_s;
          timer_d   = '0;
        end else if (pg_i[idx_q]) begin
          state_d = ST_SETTLE;
          timer_d = '0;
        end else if (timer_q == TIMER_WIDTH'(PG_TIMEOUT - 1)) begin
          state_d      = ST_FAULT;
          rail_en_d    = '0;
          fault_d      = 1'b1;
          fault_rail_d = RAIL_ONE << idx_q;
          timer_d      = '0;
        end else begin
          timer_d = timer_q + TIMER_WIDTH'(1);
        end
      end
      ST_SETTLE: begin
        if (|fail_s) begin
          state_d      = ST_FAULT;
          rail_en_d    = '0;
          fault_d      = 1'b1;
          fault_rail_d = first_fail_s;
          timer_d      = '0;
        end else if (!enable_i) begin
          state_d   = (down_en_s == '0) ? ST_OFF : ST_RAMP_DOWN;
          rail_en_d = down_en_s;
          timer_d   = '0;
        end else if (timer_q == TIMER_WIDTH'(SETTLE_CYCLES - 1)) begin
          timer_d = '0;
          if (idx_q == IDX_W'(NUM_RAILS - 1)) begin
            state_d = ST_ON;
`ifdef AUTO_RETRY_EN
            retry_d = '0;
`endif
          end else begin
            state_d   = ST_RAMP_UP;
            idx_d     = idx_q + IDX_W'(1);
            rail_en_d = rail_en_q | (RAIL_ONE << (idx_q + IDX_W'(1)));
          end
        end else begin
          timer_d = timer_q + TIMER_WIDTH'(1);
        end
      end
      ST_ON: begin
        timer_d = '0;
        if (|fail_s) begin
          state_d      = ST_FAULT;
          rail_en_d    = '0;
          fault_d      = 1'b1;
          fault_rail_d = first_fail_s;
        end else if (!enable_i) begin
          state_d   = (down_en_s == '0) ? ST_OFF : ST_RAMP_DOWN;
          rail_en_d = down_en_s;
        end else begin
          state_d = ST_ON;
        end
      end
      ST_RAMP_DOWN: begin
        if (timer_q == TIMER_WIDTH'(SETTLE_CYCLES - 1)) begin
          rail_en_d = down_en_s;
          timer_d   = '0;
          state_d   = (down_en_s == '0) ? ST_OFF : ST_RAMP_DOWN;
        end else begin
          timer_d = timer_q + TIMER_WIDTH'(1);
        end
      end
      ST_FAULT: begin
        timer_d   = '0;
        rail_en_d = '0;
        if (clear_fault_i && !enable_i) begin
          state_d      = ST_OFF;
          fault_d      = 1'b0;
          fault_rail_d = '0;
`ifdef AUTO_RETRY_EN
          retry_d      = '0;
        end else if (enable_i && (retry_q < RETRY_W'(RETRY_LIMIT))) begin
          // The FAULT cycle counts toward the delay, so the timer starts at one.
          state_d = ST_RETRY_WAIT;
          retry_d = retry_q + RETRY_W'(1);
          timer_d = TIMER_WIDTH'(1);
`endif
        end else begin
          state_d = ST_FAULT;
        end
      end
`ifdef AUTO_RETRY_EN
      ST_RETRY_WAIT: begin
        rail_en_d = '0;
        if (!enable_i) begin
          state_d = ST_FAULT;
          timer_d = '0;
        end else if (timer_q == TIMER_WIDTH'(RETRY_DELAY - 1)) begin
          state_d   = ST_RAMP_UP;
          idx_d     = '0;
          rail_en_d = RAIL_ONE;
          timer_d   = '0;
        end else begin
          timer_d = timer_q + TIMER_WIDTH'(1);
        end
      end
`endif
      default: begin
        // Illegal encoding: drop every rail and latch a fault.
        state_d   = ST_FAULT;
        rail_en_d = '0;
        fault_d   = 1'b1;
        timer_d   = '0;
      end
    endcase
    all_good_d = (state_q == ST_ON) && (state_d == ST_ON);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge sysclk_i) begin
    if (reset_i) begin
      state_q      <= ST_OFF;
      timer_q      <= '0;
      idx_q        <= '0;
      rail_en_q    <= '0;
      all_good_q   <= 1'b0;
      fault_q      <= 1'b0;
      fault_rail_q <= '0;
`ifdef AUTO_RETRY_EN
      retry_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      idx_q        <= idx_d;
      rail_en_q    <= rail_en_d;
      all_good_q   <= all_good_d;
      fault_q      <= fault_d;
      fault_rail_q <= fault_rail_d;
`ifdef AUTO_RETRY_EN
      retry_q      <= retry_d;
`endif
    end
  end

  assign rail_en_o    = rail_en_q;
  assign all_good_o   = all_good_q;
  assign fault_o      = fault_q;
  assign fault_rail_o = fault_rail_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_rail_sequencer.sv
// Directed bench for rail_sequencer (3 rails, short timers) with a behavioural pg model
// and an expected-output queue; the retry scenario runs when AUTO_RETRY_EN is defined.
module tb_rail_sequencer;

  localparam int NR = 3;

  logic          sysclk = 1'b0;
  logic          reset;
  logic          enable;
  logic [NR-1:0] pg;
  logic          clear_fault;
  logic [NR-1:0] rail_en;
  logic          all_good;
  logic          fault;
  logic [NR-1:0] fault_rail;
  logic [2:0]    state;

  always #5 sysclk = ~sysclk;

  rail_sequencer #(
    .NUM_RAILS(NR), .TIMER_WIDTH(16), .PG_TIMEOUT(20),
    .SETTLE_CYCLES(5), .RETRY_DELAY(10), .RETRY_LIMIT(2)
  ) dut (
    .sysclk_i(sysclk), .reset_i(reset), .enable_i(enable), .pg_i(pg),
    .clear_fault_i(clear_fault), .rail_en_o(rail_en), .all_good_o(all_good),
    .fault_o(fault), .fault_rail_o(fault_rail), .state_o(state)
  );

  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  int            cnt [NR];
  logic [NR-1:0] stuck;
  logic [NR-1:0] drop;
  logic [10:0]   sb_q [$];

  function automatic logic [10:0] pack(input logic [2:0] st, input logic [2:0] en,
                                       input logic ag, input logic f, input logic [2:0] fr);
    return {st, en, ag, f, fr};
  endfunction

  // Regulator model: pg rises on the third negedge after its enable is seen high.
  task automatic apply_pg();
    for (int i = 0; i < NR; i++) pg[i] = (cnt[i] >= 3) && !stuck[i] && !drop[i];
  endtask

  task automatic tick();
    @(negedge sysclk);
    cyc++;
    for (int i = 0; i < NR; i++) cnt[i] = rail_en[i] ? cnt[i] + 1 : 0;
    apply_pg();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic expect_out(input logic [10:0] e);
    sb_q.push_back(e);
  endtask

  task automatic check_out(input string tag);
    logic [10:0] e;
    logic [10:0] o;
    e = sb_q.pop_front();
    o = pack(state, rail_en, all_good, fault, fault_rail);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: observed {st,en,ag,f,fr}=%b expected=%b", tag, o, e);
    end
  endtask

  task automatic check_val(input string tag, input int o, input int e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  task automatic wait_en(input string tag, input logic [2:0] want, input int budget, output int at);
    bit hit;
    hit = 1'b0;
    at  = -1;
    for (int k = 0; k < budget && !hit; k++) begin
      tick();
      if (rail_en === want) begin
        hit = 1'b1;
        at  = cyc;
      end
    end
    total++;
    assert (hit) else begin
      bad++;
      $error("FAIL %s: observed=timeout expected rail_en=%b within %0d cycles", tag, want, budget);
    end
  endtask

  task automatic wait_st(input string tag, input logic [2:0] want, input int budget, output int at);
    bit hit;
    hit = 1'b0;
    at  = -1;
    for (int k = 0; k < budget && !hit; k++) begin
      tick();
      if (state === want) begin
        hit = 1'b1;
        at  = cyc;
      end
    end
    total++;
    assert (hit) else begin
      bad++;
      $error("FAIL %s: observed=timeout expected state=%0d within %0d cycles", tag, want, budget);
    end
  endtask

  task automatic fault_clear(input string tag);
    drop        = '0;
    apply_pg();
    enable      = 1'b0;
    clear_fault = 1'b1;
    expect_out(pack(3'd0, 3'b000, 1'b0, 1'b0, 3'b000));
    tick();
    check_out(tag);
    clear_fault = 1'b0;
  endtask

  initial begin
    int t0, t1, t2, t3;
    reset = 1'b1; enable = 1'b0; clear_fault = 1'b0;
    stuck = '0; drop = '0;
    for (int i = 0; i < NR; i++) cnt[i] = 0;
    apply_pg();
    ticks(3);
    expect_out(pack(3'd0, 3'b000, 1'b0, 1'b0, 3'b000));
    check_out("reset_state");
    reset = 1'b0;
    tick();

    // Normal ramp-up.
    enable = 1'b1;
    wait_en("up_rail0", 3'b001, 5, t0);
    wait_en("up_rail1", 3'b011, 20, t1);
    wait_en("up_rail2", 3'b111, 20, t2);
    check_val("up_spacing01", t1 - t0, 8);
    check_val("up_spacing12", t2 - t1, 8);
    wait_st("on_reach", 3'd3, 20, t3);
    check_val("on_delay", t3 - t2, 8);
    expect_out(pack(3'd3, 3'b111, 1'b0, 1'b0, 3'b000));
    check_out("on_entry");
    expect_out(pack(3'd3, 3'b111, 1'b1, 1'b0, 3'b000));
    tick();
    check_out("on_all_good");

    // Power down in reverse order.
    enable = 1'b0;
    expect_out(pack(3'd4, 3'b011, 1'b0, 1'b0, 3'b000));
    tick();
    check_out("down_first");
    t0 = cyc;
    wait_en("down_rail1", 3'b001, 10, t1);
    wait_en("down_rail0", 3'b000, 10, t2);
    check_val("down_spacing1", t1 - t0, 5);
    check_val("down_spacing0", t2 - t1, 5);
    expect_out(pack(3'd0, 3'b000, 1'b0, 1'b0, 3'b000));
    check_out("down_off");

    // Power-good timeout on rail 1.
    stuck  = 3'b010;
    enable = 1'b1;
    wait_en("to_rail1", 3'b011, 20, t0);
    wait_st("to_fault", 3'd5, 40, t1);
    check_val("to_latency", t1 - t0, 20);
    expect_out(pack(3'd5, 3'b000, 1'b0, 1'b1, 3'b010));
    check_out("to_fault_outputs");
`ifndef AUTO_RETRY_EN
    clear_fault = 1'b1;
    ticks(3);
    expect_out(pack(3'd5, 3'b000, 1'b0, 1'b1, 3'b010));
    check_out("clear_while_enabled");
`endif
    stuck = '0;
    fault_clear("to_clear_off");

    // Single-cycle dropout of rail 0 while ON.
    enable = 1'b1;
    wait_st("on_reach2", 3'd3, 60, t0);
    tick();
    drop = 3'b001;
    apply_pg();
    expect_out(pack(3'd5, 3'b000, 1'b0, 1'b1, 3'b001));
    tick();
    check_out("dropout_r0");
    fault_clear("dropout_r0_clear");

    // Rails 0 and 2 fail together: lowest index reported.
    enable = 1'b1;
    wait_st("on_reach3", 3'd3, 60, t0);
    drop = 3'b101;
    apply_pg();
    expect_out(pack(3'd5, 3'b000, 1'b0, 1'b1, 3'b001));
    tick();
    check_out("dropout_r0r2");
    fault_clear("dropout_r0r2_clear");

    // Enable drop and rail 2 failure in the same cycle.
    enable = 1'b1;
    wait_st("on_reach4", 3'd3, 60, t0);
    enable = 1'b0;
    drop   = 3'b100;
    apply_pg();
    expect_out(pack(3'd5, 3'b000, 1'b0, 1'b1, 3'b100));
    tick();
    check_out("fault_beats_disable");
    fault_clear("fault_beats_disable_clear");

    // Reset during SETTLE drops all rails on the next edge.
    enable = 1'b1;
    wait_st("settle_reach", 3'd2, 10, t0);
    reset = 1'b1;
    expect_out(pack(3'd0, 3'b000, 1'b0, 1'b0, 3'b000));
    tick();
    check_out("reset_in_settle");
    reset  = 1'b0;
    enable = 1'b0;
    tick();

    // Rail 0 stuck low: retry behaviour depends on the build.
    stuck  = 3'b001;
    enable = 1'b1;
`ifdef AUTO_RETRY_EN
    for (int r = 0; r < 2; r++) begin
      wait_st("retry_fault", 3'd5, 40, t0);
      wait_en("retry_rampup", 3'b001, 20, t1);
      check_val("retry_delay", t1 - t0, 10);
    end
    wait_st("retry_final_fault", 3'd5, 40, t0);
    ticks(20);
    expect_out(pack(3'd5, 3'b000, 1'b0, 1'b1, 3'b001));
    check_out("retry_exhausted");
`else
    wait_en("nr_rail0", 3'b001, 5, t0);
    wait_st("nr_fault", 3'd5, 40, t1);
    check_val("nr_latency", t1 - t0, 20);
    ticks(15);
    expect_out(pack(3'd5, 3'b000, 1'b0, 1'b1, 3'b001));
    check_out("no_retry_latched");
`endif
    stuck = '0;
    fault_clear("final_clear");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
